// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared constants for the bit-serial subtractor.
// This package holds the FSM state encoding and a constant-foldable clog2.
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit-counter width. Never returns less than 1, so a counter always exists.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: a 1-bit combinational cell that computes x - y - bi.
// It is the inverse counterpart of the full adder.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference bit and borrow out of one bit position
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: an LSB-first bit-serial subtractor built from one
// full_subtractor cell and a registered borrow.
// Optional macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
//
// Handshake: a start seen on a rising edge while the FSM is in IDLE is
// accepted, and a, b and bin are captured on that edge. busy is high for
// the WIDTH cycles of RUN. done pulses for exactly one cycle, and during that
// cycle diff/bout are valid. start is ignored while busy or done. diff and
// bout hold their values until the next accepted start.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // state is kept as a plainly named register so it can be probed directly.
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

    assign last_bit = (cnt == LAST);

    full_subtractor u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (borrow),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // FSM state register; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE on last bit, DONE -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)    state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from registered state only
    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // Datapath: capture on start, then one bit per cycle while in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (state == ST_IDLE && start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
            diff   <= '0;
        end else if (state == ST_RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            diff   <= {cell_d, diff[WIDTH-1:1]};
            borrow <= cell_bo;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                bout <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                // On the final bit, the shifters present the captured operand MSBs
                ovf  <= (a_sr[0] != b_sr[0]) && (cell_d != a_sr[0]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: a self-checking bench for serial_subtractor (WIDTH=8)
// plus a standalone full_subtractor.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
    logic             exp_ovf_q[$];
`endif

    logic [WIDTH:0] exp_q[$];   // {bout, diff}
    int n_cmp;
    int n_err;

    logic fs_x, fs_y, fs_bi, fs_d, fs_bo;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    full_subtractor u_fs (
        .x  (fs_x),
        .y  (fs_y),
        .bi (fs_bi),
        .d  (fs_d),
        .bo (fs_bo)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer arithmetic, independent of the bit-serial structure
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                             input logic mbin);
        int r;
        logic [31:0] t;
        r = int'(ma) - int'(mb) - int'(mbin);
        t = r;
        return {(r < 0), t[WIDTH-1:0]};
    endfunction

    function automatic logic model_ovf(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                       input logic mbin);
        int sa, sb, r;
        sa = $signed(ma);
        sb = $signed(mb);
        r  = sa - sb - int'(mbin);
        return (r < -(2 ** (WIDTH - 1))) || (r > (2 ** (WIDTH - 1)) - 1);
    endfunction

    // Driver: present operands with a one-cycle start pulse; push expectations if requested
    task automatic drive_start(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                               input logic vbin, input bit push);
        @(negedge clk);
        a = va;
        b = vb;
        bin = vbin;
        start = 1'b1;
        if (push) begin
            exp_q.push_back(model(va, vb, vbin));
`ifdef SERIAL_SUB_OVF_EN
            exp_ovf_q.push_back(model_ovf(va, vb, vbin));
`endif
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: wait (bounded) for done and count busy cycles; optionally scramble operand inputs
    task automatic wait_done(input bit scramble, output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (scramble) begin
                a = WIDTH'($urandom_range(0, 2 ** WIDTH - 1));
                b = WIDTH'($urandom_range(0, 2 ** WIDTH - 1));
                bin = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, bout, diff} !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b bout=%b diff=%h required all 0", busy, done, bout, diff);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: ovf=%b required 0", ovf);
        end
`endif
        rst = 1'b0;
    endtask

    // One operation with operand scrambling while busy; checks timing, result, pulse width, hold
    task automatic test_op(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                           input logic vbin);
        int bc;
        bit seen;
        logic [WIDTH:0] exp;
        drive_start(va, vb, vbin, 1'b1);
        wait_done(1'b1, bc, seen);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_done_timeout: done not seen within %0d cycles", name, 4 * WIDTH);
            return;
        end
        n_cmp++;
        if (bc !== WIDTH) begin
            n_err++;
            $display("FAIL %s_busy_len: busy cycles=%0d required %0d", name, bc, WIDTH);
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if ({bout, diff} !== exp) begin
            n_err++;
            $display("FAIL %s_result: bout=%b diff=%h required bout=%b diff=%h", name, bout, diff, exp[WIDTH],
                     exp[WIDTH-1:0]);
        end
`ifdef SERIAL_SUB_OVF_EN
        begin
            logic eo;
            eo = exp_ovf_q.pop_front();
            n_cmp++;
            if (ovf !== eo) begin
                n_err++;
                $display("FAIL %s_ovf: ovf=%b required %b", name, ovf, eo);
            end
        end
`endif
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || {bout, diff} !== exp) begin
            n_err++;
            $display("FAIL %s_hold: done=%b bout=%b diff=%h required done=0 bout=%b diff=%h", name, done, bout,
                     diff, exp[WIDTH], exp[WIDTH-1:0]);
        end
    endtask

    task automatic test_arith();
        test_op("sub_5_3", 8'h05, 8'h03, 1'b0);
        test_op("sub_3_5", 8'h03, 8'h05, 1'b0);
        test_op("sub_0_0_bin", 8'h00, 8'h00, 1'b1);
        test_op("sub_80_01", 8'h80, 8'h01, 1'b0);
        test_op("sub_10_01", 8'h10, 8'h01, 1'b0);
        test_op("sub_ff_00_bin", 8'hFF, 8'h00, 1'b1);
        test_op("sub_7f_ff", 8'h7F, 8'hFF, 1'b0);
        for (int i = 0; i < 6; i++)
            test_op("sub_rand", WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
    endtask

    // A start re-asserted in cycle 3 of RUN must be ignored
    task automatic test_ignored_start();
        int pulses;
        logic [WIDTH:0] exp;
        drive_start(8'h0A, 8'h04, 1'b0, 1'b1);
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        exp = '0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    exp = exp_q.pop_front();
                    n_cmp++;
                    if ({bout, diff} !== exp) begin
                        n_err++;
                        $display("FAIL ignored_start_result: bout=%b diff=%h required bout=%b diff=%h", bout,
                                 diff, exp[WIDTH], exp[WIDTH-1:0]);
                    end
`ifdef SERIAL_SUB_OVF_EN
                    void'(exp_ovf_q.pop_front());
`endif
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL ignored_start_pulses: done pulses=%0d required 1", pulses);
        end
    endtask

    // start held high: operations issue at the minimum interval of WIDTH+2 cycles
    task automatic test_back_to_back();
        int bc, gap;
        bit seen;
        logic [WIDTH:0] exp;
        @(negedge clk);
        a = 8'h30;
        b = 8'h12;
        bin = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(model(8'h30, 8'h12, 1'b0));
`ifdef SERIAL_SUB_OVF_EN
            exp_ovf_q.push_back(model_ovf(8'h30, 8'h12, 1'b0));
`endif
        end
        @(negedge clk);
        wait_done(1'b0, bc, seen);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL b2b_first_timeout: done not seen");
            start = 1'b0;
            return;
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if ({bout, diff} !== exp) begin
            n_err++;
            $display("FAIL b2b_first_result: bout=%b diff=%h required bout=%b diff=%h", bout, diff, exp[WIDTH],
                     exp[WIDTH-1:0]);
        end
        gap = 0;
        seen = 1'b0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            gap++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (!seen || gap !== WIDTH + 2) begin
            n_err++;
            $display("FAIL b2b_interval: seen=%b gap=%0d required seen=1 gap=%0d", seen, gap, WIDTH + 2);
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if ({bout, diff} !== exp) begin
            n_err++;
            $display("FAIL b2b_second_result: bout=%b diff=%h required bout=%b diff=%h", bout, diff, exp[WIDTH],
                     exp[WIDTH-1:0]);
        end
`ifdef SERIAL_SUB_OVF_EN
        void'(exp_ovf_q.pop_front());
        void'(exp_ovf_q.pop_front());
`endif
        @(negedge clk);
    endtask

    // Reset during RUN aborts the operation with no done pulse, and a later operation still works
    task automatic test_reset_mid_run();
        int pulses;
        drive_start(8'h55, 8'h11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state: busy=%b done=%b diff=%h bout=%b required all 0", busy, done, diff, bout);
        end
        pulses = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses !== 0 || diff !== '0) begin
            n_err++;
            $display("FAIL abort_no_done: pulses=%0d diff=%h required 0 and 00", pulses, diff);
        end
        test_op("after_abort_9_9", 8'h09, 8'h09, 1'b0);
    endtask

    // Standalone cell: all 8 input combinations against integer subtraction
    task automatic test_full_subtractor();
        int r;
        for (int v = 0; v < 8; v++) begin
            fs_x = v[2];
            fs_y = v[1];
            fs_bi = v[0];
            #1;
            r = int'(v[2]) - int'(v[1]) - int'(v[0]);
            n_cmp++;
            if (fs_d !== r[0] || fs_bo !== (r < 0)) begin
                n_err++;
                $display("FAIL fs_vec_%0d%0d%0d: d=%b bo=%b required d=%b bo=%b", v[2], v[1], v[0], fs_d, fs_bo,
                         r[0], (r < 0));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        fs_x = 1'b0;
        fs_y = 1'b0;
        fs_bi = 1'b0;
        test_reset();
        test_full_subtractor();
        test_arith();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
